gate_op_arbiter: RTL and testbench

GATE_OP_ARBITER -- requirements
Module: gate_op_arbiter

---
 rtl/gate_arb_pkg.sv | 18 +
 rtl/three_input_gate_core.sv | 28 ++
 rtl/gate_op_arbiter.sv | 175 +++++++++++++++++
 tb/tb_gate_op_arbiter.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gate_arb_pkg.sv
// gate_arb_pkg
//   Shared definitions for the gate operation arbiter:
//   - function codes understood by the three-input gate evaluator
//   - FSM state encoding used by gate_op_arbiter
package gate_arb_pkg;

  localparam logic [1:0] CODE_AND3 = 2'b00;
  localparam logic [1:0] CODE_OR3  = 2'b01;
  localparam logic [1:0] CODE_XOR3 = 2'b10;
  localparam logic [1:0] CODE_MAJ3 = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EVAL = 2'd1,
    ST_RESP = 2'd2
  } arb_state_e;

endpackage

// File: rtl/three_input_gate_core.sv
// three_input_gate_core
//   Purely combinational three-input gate evaluator.
//   Ports:
//     i_a, i_b, i_c : gate operands
//     i_code        : function select (AND3, OR3, XOR3 odd parity, MAJ3)
//     o_f           : gate result
module three_input_gate_core
  import gate_arb_pkg::*;
(
  input  logic       i_a,
  input  logic       i_b,
  input  logic       i_c,
  input  logic [1:0] i_code,
  output logic       o_f
);

  always_comb begin
    o_f = 1'b0;
    case (i_code)
      CODE_AND3: o_f = i_a & i_b & i_c;
      CODE_OR3:  o_f = i_a | i_b | i_c;
      CODE_XOR3: o_f = i_a ^ i_b ^ i_c;
      CODE_MAJ3: o_f = (i_a & i_b) | (i_a & i_c) | (i_b & i_c);
      default:   o_f = 1'b0;
    endcase
  end

endmodule

// File: rtl/gate_op_arbiter.sv
// gate_op_arbiter
//   Shares one three-input gate evaluator among N_REQ requesters. One
//   operation is in flight at a time: IDLE accepts a request, EVAL registers
//   the gate result, RESP holds the result until the owner accepts it.
//   Ports:
//     i_clk, i_rst_n : clock, synchronous active-low reset
//     i_req_valid    : per-requester request
//     o_req_ready    : one-hot accept strobe (combinational in the IDLE cycle)
//     i_req_a/b/c    : per-requester operands
//     i_req_code     : per-requester 2-bit function code, requester k at [2k+1:2k]
//     o_rsp_valid    : one-hot result valid to the owning requester
//     i_rsp_ready    : per-requester result acceptance (only the owner's bit matters)
//     o_rsp_f        : result bit
//     o_busy         : high whenever the FSM is not in IDLE
//   Configuration macro: GATE_ARB_FIXED_PRIO_EN
//     undefined (default): round-robin arbitration starting from a pointer
//     defined            : fixed priority, lowest valid index wins, no pointer
module gate_op_arbiter
  import gate_arb_pkg::*;
#(
  parameter int N_REQ = 4
)
(
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [N_REQ-1:0]   i_req_valid,
  output logic [N_REQ-1:0]   o_req_ready,
  input  logic [N_REQ-1:0]   i_req_a,
  input  logic [N_REQ-1:0]   i_req_b,
  input  logic [N_REQ-1:0]   i_req_c,
  input  logic [2*N_REQ-1:0] i_req_code,
  output logic [N_REQ-1:0]   o_rsp_valid,
  input  logic [N_REQ-1:0]   i_rsp_ready,
  output logic               o_rsp_f,
  output logic               o_busy
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [N_REQ-1:0] ONE_HOT0 = {{(N_REQ-1){1'b0}}, 1'b1};

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] grant_q, grant_d;
  logic             a_q, a_d;
  logic             b_q, b_d;
  logic             c_q, c_d;
  logic [1:0]       code_q, code_d;
  logic             rsp_f_q, rsp_f_d;

  logic [IDX_W-1:0] win_idx;
  logic             win_found;
  logic             gate_f;

`ifndef GATE_ARB_FIXED_PRIO_EN
  logic [IDX_W-1:0] ptr_q, ptr_d;
`endif

  // Arbitration: loops run from the far end back toward the preferred start
  // so the last assignment (the closest candidate) is the winner.
`ifdef GATE_ARB_FIXED_PRIO_EN
  always_comb begin
    win_idx   = '0;
    win_found = 1'b0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (i_req_valid[IDX_W'(k)]) begin
        win_idx   = IDX_W'(k);
        win_found = 1'b1;
      end
    end
  end
`else
  always_comb begin
    int               idx;
    logic [IDX_W-1:0] cand;
    win_idx   = '0;
    win_found = 1'b0;
    idx       = 0;
    cand      = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      idx = int'(ptr_q) + i;
      if (idx >= N_REQ) begin
        idx = idx - N_REQ;
      end
      cand = IDX_W'(idx);
      if (i_req_valid[cand]) begin
        win_idx   = cand;
        win_found = 1'b1;
      end
    end
  end
`endif

  three_input_gate_core u_core (
    .i_a    (a_q),
    .i_b    (b_q),
    .i_c    (c_q),
    .i_code (code_q),
    .o_f    (gate_f)
  );

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    a_d         = a_q;
    b_d         = b_q;
    c_d         = c_q;
    code_d      = code_q;
    rsp_f_d     = rsp_f_q;
    o_req_ready = '0;
`ifndef GATE_ARB_FIXED_PRIO_EN
    ptr_d       = ptr_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          o_req_ready = ONE_HOT0 << win_idx;
          grant_d     = win_idx;
          a_d         = i_req_a[win_idx];
          b_d         = i_req_b[win_idx];
          c_d         = i_req_c[win_idx];
          code_d      = i_req_code[{win_idx, 1'b0} +: 2];
          state_d     = ST_EVAL;
        end
      end
      ST_EVAL: begin
        rsp_f_d = gate_f;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (i_rsp_ready[grant_q]) begin
          state_d = ST_IDLE;
`ifndef GATE_ARB_FIXED_PRIO_EN
          ptr_d   = (grant_q == IDX_W'(N_REQ - 1)) ? '0 : grant_q + 1'b1;
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // The accept strobe is combinational, so it must be masked while reset
    // is held or a requester could believe it was accepted.
    if (!i_rst_n) begin
      o_req_ready = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      c_q     <= 1'b0;
      code_q  <= 2'b00;
      rsp_f_q <= 1'b0;
`ifndef GATE_ARB_FIXED_PRIO_EN
      ptr_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      code_q  <= code_d;
      rsp_f_q <= rsp_f_d;
`ifndef GATE_ARB_FIXED_PRIO_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

  assign o_rsp_valid = (state_q == ST_RESP) ? (ONE_HOT0 << grant_q) : '0;
  assign o_rsp_f     = rsp_f_q;
  assign o_busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_gate_op_arbiter.sv
// tb_gate_op_arbiter
//   Directed and randomized bench for gate_op_arbiter with N_REQ=4. A
//   transaction-level reference model (owner, age of the operation, pointer,
//   precomputed result) predicts every output each cycle.
//   Honours GATE_ARB_FIXED_PRIO_EN the same way as the design.
module tb_gate_op_arbiter;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N-1:0]   req_a;
  logic [N-1:0]   req_b;
  logic [N-1:0]   req_c;
  logic [2*N-1:0] req_code;
  logic [N-1:0]   rsp_valid;
  logic [N-1:0]   rsp_ready;
  logic           rsp_f;
  logic           busy;

  always #5 clk = ~clk;

  gate_op_arbiter #(.N_REQ(N)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_req_valid (req_valid),
    .o_req_ready (req_ready),
    .i_req_a     (req_a),
    .i_req_b     (req_b),
    .i_req_c     (req_c),
    .i_req_code  (req_code),
    .o_rsp_valid (rsp_valid),
    .i_rsp_ready (rsp_ready),
    .o_rsp_f     (rsp_f),
    .o_busy      (busy)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: owner is -1 when nothing is in flight; age counts
  // cycles since the accept edge (1 = evaluating, 2 = responding).
  int   m_owner = -1;
  int   m_age   = 0;
  int   m_ptr   = 0;
  logic m_f     = 1'b0;
  int   cycle   = 0;

  logic [N-1:0] keep_mask = '0;
  int grant_log[$];
  int grant_cyc[$];

  logic [N-1:0] cap_ready;
  logic [N-1:0] cap_rsp_valid;
  logic         cap_f;
  logic         cap_busy;

  function automatic logic gate_ref(logic a, logic b, logic c, logic [1:0] code);
    int s;
    s = int'(a) + int'(b) + int'(c);
    case (code)
      2'b00:   return (s == 3);
      2'b01:   return (s >= 1);
      2'b10:   return (s % 2 == 1);
      default: return (s >= 2);
    endcase
  endfunction

  function automatic int pick_winner(logic [N-1:0] v);
`ifdef GATE_ARB_FIXED_PRIO_EN
    for (int i = 0; i < N; i++) begin
      if (v[i]) return i;
    end
`else
    for (int i = 0; i < N; i++) begin
      if (v[(m_ptr + i) % N]) return (m_ptr + i) % N;
    end
`endif
    return -1;
  endfunction

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input int k, input logic a, input logic b, input logic c,
                                input logic [1:0] code);
    req_valid[k]         = 1'b1;
    req_a[k]             = a;
    req_b[k]             = b;
    req_c[k]             = c;
    req_code[2*k +: 2]   = code;
  endtask

  // One clock cycle: check all outputs against the model, advance the model
  // across the rising edge, then retire accepted requests at the falling edge.
  task automatic tick();
    int           w;
    logic [N-1:0] one;
    logic [N-1:0] exp_ready;
    logic [N-1:0] exp_rv;
    one = 1;
    #1;
    cap_ready     = req_ready;
    cap_rsp_valid = rsp_valid;
    cap_f         = rsp_f;
    cap_busy      = busy;
    w         = (rst_n && m_owner < 0) ? pick_winner(req_valid) : -1;
    exp_ready = (w >= 0) ? (one << w) : '0;
    exp_rv    = (m_owner >= 0 && m_age >= 2) ? (one << m_owner) : '0;
    check_output("req_ready", 32'(cap_ready), 32'(exp_ready));
    check_output("rsp_valid", 32'(cap_rsp_valid), 32'(exp_rv));
    check_output("busy", 32'(cap_busy), 32'(m_owner >= 0));
    if (exp_rv != '0) check_output("rsp_f", 32'(cap_f), 32'(m_f));
    @(posedge clk);
    cycle++;
    if (!rst_n) begin
      m_owner = -1;
      m_ptr   = 0;
    end else if (m_owner < 0) begin
      if (w >= 0) begin
        m_owner = w;
        m_age   = 1;
        m_f     = gate_ref(req_a[w], req_b[w], req_c[w], req_code[2*w +: 2]);
        grant_log.push_back(w);
        grant_cyc.push_back(cycle);
      end
    end else if (m_age == 1) begin
      m_age = 2;
    end else if (rsp_ready[m_owner]) begin
      m_ptr   = (m_owner + 1) % N;
      m_owner = -1;
    end
    @(negedge clk);
    if (w >= 0 && !keep_mask[w]) req_valid[w] = 1'b0;
  endtask

  task automatic apply_reset(input int n);
    rst_n = 1'b0;
    repeat (n) tick();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [3:0] sweep_exp;
    int         rr_exp[5];
    rr_exp    = '{0, 1, 2, 3, 0};
    sweep_exp = 4'b1010;

    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_c     = '0;
    req_code  = '0;
    rsp_ready = '1;
    @(negedge clk);
    $display("[TB] reset");
    req_valid = 4'b0001;
    apply_reset(2);
    req_valid = '0;
    check_output("reset_busy", 32'(cap_busy), 32'd0);
    check_output("reset_ready", 32'(cap_ready), 32'd0);

    $display("[TB] single request");
    apply_stimulus(0, 1'b1, 1'b1, 1'b0, 2'b11);
    tick();
    check_output("single_ready0", 32'(cap_ready), 32'h1);
    tick();
    check_output("single_eval_rv", 32'(cap_rsp_valid), 32'h0);
    tick();
    check_output("single_rv0", 32'(cap_rsp_valid), 32'h1);
    check_output("single_f", 32'(cap_f), 32'h1);

    $display("[TB] code sweep on req2");
    for (int code = 0; code < 4; code++) begin
      apply_stimulus(2, 1'b1, 1'b0, 1'b1, 2'(code));
      tick();
      tick();
      tick();
      check_output($sformatf("sweep_f_code%0d", code), 32'(cap_f), 32'(sweep_exp[code]));
    end

    $display("[TB] round robin, all requesters valid");
    apply_reset(2);
    grant_log.delete();
    grant_cyc.delete();
    keep_mask = '1;
    for (int k = 0; k < N; k++)
      apply_stimulus(k, 1'($urandom), 1'($urandom), 1'($urandom), 2'($urandom));
    repeat (15) tick();
    check_output("rr_grant_count", 32'(grant_log.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < grant_log.size()) begin
        check_output($sformatf("rr_grant%0d", i), 32'(grant_log[i]), 32'(rr_exp[i]));
        if (i > 0)
          check_output($sformatf("rr_interval%0d", i), 32'(grant_cyc[i] - grant_cyc[i-1]), 32'd3);
      end
    end
    keep_mask = '0;
    req_valid = '0;
    repeat (3) tick();

    $display("[TB] stalled response");
    rsp_ready = 4'b1101;
    apply_stimulus(1, 1'b1, 1'b0, 1'b0, 2'b01);
    tick();
    check_output("stall_ready1", 32'(cap_ready), 32'h2);
    apply_stimulus(3, 1'b1, 1'b1, 1'b1, 2'b00);
    tick();
    repeat (5) begin
      tick();
      check_output("stall_rv1", 32'(cap_rsp_valid), 32'h2);
      check_output("stall_busy", 32'(cap_busy), 32'h1);
      check_output("stall_no_ready", 32'(cap_ready), 32'h0);
      check_output("stall_f", 32'(cap_f), 32'h1);
    end
    rsp_ready = '1;
    tick();
    tick();
    check_output("stall_ready3", 32'(cap_ready), 32'h8);
    tick();
    tick();

    $display("[TB] reset during evaluation");
    apply_stimulus(0, 1'b1, 1'b1, 1'b1, 2'b10);
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    check_output("abort_busy", 32'(cap_busy), 32'h0);
    check_output("abort_f", 32'(cap_f), 32'h0);
    check_output("abort_ready", 32'(cap_ready), 32'h0);
    repeat (3) begin
      tick();
      check_output("abort_rv", 32'(cap_rsp_valid), 32'h0);
    end

    $display("[TB] req0 and req2 continuously valid");
    apply_reset(1);
    grant_log.delete();
    keep_mask = 4'b0101;
    apply_stimulus(0, 1'b0, 1'b1, 1'b1, 2'b11);
    apply_stimulus(2, 1'b1, 1'b0, 1'b0, 2'b10);
    repeat (12) tick();
    check_output("prio_grant_count", 32'(grant_log.size()), 32'd4);
    for (int i = 0; i < grant_log.size(); i++) begin
`ifdef GATE_ARB_FIXED_PRIO_EN
      check_output($sformatf("prio_grant%0d", i), 32'(grant_log[i]), 32'd0);
`else
      check_output($sformatf("prio_grant%0d", i), 32'(grant_log[i]), (i % 2 == 0) ? 32'd0 : 32'd2);
`endif
    end
    keep_mask = '0;
    req_valid = '0;
    repeat (3) tick();

    $display("[TB] randomized traffic");
    repeat (600) begin
      for (int k = 0; k < N; k++) begin
        if (!req_valid[k] && $urandom_range(0, 2) == 0)
          apply_stimulus(k, 1'($urandom), 1'($urandom), 1'($urandom), 2'($urandom));
      end
      rsp_ready = N'($urandom);
      rst_n     = ($urandom_range(0, 150) != 0);
      tick();
    end
    rst_n     = 1'b1;
    req_valid = '0;
    rsp_ready = '1;
    repeat (4) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
